rd_writeback_track: RTL and testbench

- Writer-side counterpart of the ID-stage hazard detector in the 5-stage RISC-V pipeline.
- Carries each instruction's destination register number, register-file write enable, write-back source select and write-back data from ID through EX, MEM and WB.
- Publishes the per-stage destination tuples (ex_*, mem_*, wb_*) that the hazard detector compares and forwards from.
- Inserts bubbles into EX on pipeline_stop or pipeline_flush.

---
 rtl/pipe_pkg.sv | 40 ++++
 rtl/rd_writeback_track_if.sv | 37 +++
 rtl/rd_writeback_track_stage.sv | 23 ++
 rtl/rd_writeback_track.sv | 107 ++++++++++
 tb/tb_rd_writeback_track.sv | 371 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types for the write-back tracker: write-back select encoding,
// default widths and the per-stage destination tuple.
package pipe_pkg;

   localparam int unsigned DEF_XLEN = 32;
   localparam int unsigned DEF_REGW = 5;

   typedef enum logic [1:0] {
      WB_ALU  = 2'd0,
      WB_DRAM = 2'd1,
      WB_PC4  = 2'd2,
      WB_EXT  = 2'd3
   } wb_sel_e;

   typedef struct packed {
      logic                valid;
      logic [DEF_REGW-1:0] wr;
      logic                we;
      wb_sel_e             rf_wesl;
      logic [DEF_XLEN-1:0] pc4;
      logic [DEF_XLEN-1:0] ext;
      logic [DEF_XLEN-1:0] wd;
   } stage_t;

   localparam stage_t STAGE_BUBBLE = '{
      valid:   1'b0,
      wr:      '0,
      we:      1'b0,
      rf_wesl: WB_ALU,
      pc4:     '0,
      ext:     '0,
      wd:      '0
   };

   // x0 is hardwired, so a stage never reports it as written
   function automatic logic eff_we(input stage_t s);
      return s.we & s.valid & (s.wr != '0);
   endfunction

endpackage

// File: rtl/rd_writeback_track_if.sv
// Bus between ID-stage control and the write-back tracker: ID inputs, datapath
// taps and the per-stage destination tuples published to the hazard detector.
interface rd_writeback_track_if #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned REGW = 5
);
   logic            pipeline_stop;
   logic            pipeline_flush;
   logic            id_valid;
   logic [REGW-1:0] id_wr;
   logic            id_we;
   logic [1:0]      id_rf_wesl;
   logic [XLEN-1:0] id_pc4;
   logic [XLEN-1:0] id_ext;
   logic [XLEN-1:0] ex_alu_c;
   logic [XLEN-1:0] mem_dram_rd;

   logic [REGW-1:0] ex_wr, mem_wr, wb_wr;
   logic            ex_we, mem_we, wb_we;
   logic [1:0]      ex_rf_wesl;
   logic [XLEN-1:0] ex_wd, mem_wd, wb_wd;
   logic            wb_valid;

   modport master (
      output pipeline_stop, pipeline_flush, id_valid, id_wr, id_we, id_rf_wesl,
             id_pc4, id_ext, ex_alu_c, mem_dram_rd,
      input  ex_wr, mem_wr, wb_wr, ex_we, mem_we, wb_we, ex_rf_wesl,
             ex_wd, mem_wd, wb_wd, wb_valid
   );

   modport slave (
      input  pipeline_stop, pipeline_flush, id_valid, id_wr, id_we, id_rf_wesl,
             id_pc4, id_ext, ex_alu_c, mem_dram_rd,
      output ex_wr, mem_wr, wb_wr, ex_we, mem_we, wb_we, ex_rf_wesl,
             ex_wd, mem_wd, wb_wd, wb_valid
   );
endinterface

// File: rtl/rd_writeback_track_stage.sv
// One pipeline stage tuple register with async active-high reset and a bubble
// input that loads an empty slot in place of the incoming tuple.
module rd_stage_reg
   import pipe_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   bubble,
   input  stage_t d,
   output stage_t q
);

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         q <= STAGE_BUBBLE;
      end else if (bubble) begin
         q <= STAGE_BUBBLE;
      end else begin
         q <= d;
      end
   end

endmodule

// File: rtl/rd_writeback_track.sv
// Carries destination register, write enable, write-back select and data from
// ID through EX/MEM/WB. Optional retire counter: define RD_TRACK_RETIRE_CNT_EN.
module rd_writeback_track
   import pipe_pkg::*;
#(
   parameter int unsigned XLEN = DEF_XLEN,
   parameter int unsigned REGW = DEF_REGW
) (
   input  logic                 clk,
   input  logic                 rst_n,
   rd_writeback_track_if.slave  bus
`ifdef RD_TRACK_RETIRE_CNT_EN
   ,
   output logic [63:0]          retire_cnt
`endif
);

   stage_t          ex_d, ex_q, mem_d, mem_q, wb_d, wb_q;
   logic            ex_bubble;
   logic [XLEN-1:0] ex_wd_c;
   logic [XLEN-1:0] mem_wd_c;
   logic [REGW-1:0] ex_wr_c, mem_wr_c, wb_wr_c;

   assign ex_bubble = bus.pipeline_stop | bus.pipeline_flush | ~bus.id_valid;

   always_comb begin
      ex_d         = STAGE_BUBBLE;
      ex_d.valid   = 1'b1;
      ex_d.wr      = bus.id_wr;
      ex_d.we      = bus.id_we;
      ex_d.rf_wesl = wb_sel_e'(bus.id_rf_wesl);
      ex_d.pc4     = bus.id_pc4;
      ex_d.ext     = bus.id_ext;
   end

   // Load data is not available in EX; the hazard detector stalls on that case
   always_comb begin
      ex_wd_c = '0;
      unique case (ex_q.rf_wesl)
         WB_ALU:  ex_wd_c = bus.ex_alu_c;
         WB_DRAM: ex_wd_c = '0;
         WB_PC4:  ex_wd_c = ex_q.pc4;
         WB_EXT:  ex_wd_c = ex_q.ext;
         default: ex_wd_c = '0;
      endcase
   end

   assign mem_wd_c = (mem_q.rf_wesl == WB_DRAM) ? bus.mem_dram_rd : mem_q.wd;

   always_comb begin
      mem_d    = ex_q;
      mem_d.wd = ex_wd_c;
      wb_d     = mem_q;
      wb_d.wd  = mem_wd_c;
   end

   rd_stage_reg u_ex (
      .clk    (clk),
      .rst_n  (rst_n),
      .bubble (ex_bubble),
      .d      (ex_d),
      .q      (ex_q)
   );

   rd_stage_reg u_mem (
      .clk    (clk),
      .rst_n  (rst_n),
      .bubble (1'b0),
      .d      (mem_d),
      .q      (mem_q)
   );

   rd_stage_reg u_wb (
      .clk    (clk),
      .rst_n  (rst_n),
      .bubble (1'b0),
      .d      (wb_d),
      .q      (wb_q)
   );

   assign ex_wr_c  = ex_q.wr;
   assign mem_wr_c = mem_q.wr;
   assign wb_wr_c  = wb_q.wr;

   assign bus.ex_wr      = ex_wr_c;
   assign bus.mem_wr     = mem_wr_c;
   assign bus.wb_wr      = wb_wr_c;
   assign bus.ex_we      = eff_we(ex_q);
   assign bus.mem_we     = eff_we(mem_q);
   assign bus.wb_we      = eff_we(wb_q);
   assign bus.ex_rf_wesl = ex_q.rf_wesl;
   assign bus.ex_wd      = ex_wd_c;
   assign bus.mem_wd     = mem_wd_c;
   assign bus.wb_wd      = wb_q.wd;
   assign bus.wb_valid   = wb_q.valid;

`ifdef RD_TRACK_RETIRE_CNT_EN
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         retire_cnt <= '0;
      end else if (wb_q.valid) begin
         retire_cnt <= retire_cnt + 64'd1;
      end
   end
`endif

endmodule

// File: tb/tb_rd_writeback_track.sv
// Self-checking bench for rd_writeback_track: directed scenarios plus a random
// stream checked against a slot-level pipeline model.
module tb_rd_writeback_track;

   localparam bit [1:0] S_ALU  = 2'd0;
   localparam bit [1:0] S_DRAM = 2'd1;
   localparam bit [1:0] S_PC4  = 2'd2;
   localparam bit [1:0] S_EXT  = 2'd3;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   rd_writeback_track_if #(.XLEN(32), .REGW(5)) bus ();

`ifdef RD_TRACK_RETIRE_CNT_EN
   logic [63:0] retire_cnt;
   rd_writeback_track #(.XLEN(32), .REGW(5)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .retire_cnt (retire_cnt)
   );
`else
   rd_writeback_track #(.XLEN(32), .REGW(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );
`endif

   typedef struct {
      bit        v;
      bit [4:0]  wr;
      bit        we;
      bit [1:0]  sel;
      bit [31:0] pc4;
      bit [31:0] ext;
      bit [31:0] wd;
   } slot_t;

   slot_t            m_ex, m_mem, m_wb;
   longint unsigned  m_cnt;

   function automatic slot_t empty_slot();
      slot_t s;
      s.v = 0; s.wr = 0; s.we = 0; s.sel = S_ALU; s.pc4 = 0; s.ext = 0; s.wd = 0;
      return s;
   endfunction

   function automatic bit model_we(input slot_t s);
      return s.v && s.we && (s.wr != 0);
   endfunction

   function automatic bit [31:0] model_ex_wd();
      case (m_ex.sel)
         S_ALU:   return bus.ex_alu_c;
         S_PC4:   return m_ex.pc4;
         S_EXT:   return m_ex.ext;
         default: return 32'd0;
      endcase
   endfunction

   function automatic bit [31:0] model_mem_wd();
      return (m_mem.sel == S_DRAM) ? bus.mem_dram_rd : m_mem.wd;
   endfunction

   task automatic model_clear();
      m_ex = empty_slot(); m_mem = empty_slot(); m_wb = empty_slot(); m_cnt = 0;
   endtask

   // Advance one clock: model computes what each stage should hold after the edge
   task automatic tick();
      slot_t nex, nmem, nwb;
      nwb = m_mem;
      nwb.wd = model_mem_wd();
      nmem = m_ex;
      nmem.wd = model_ex_wd();
      if (bus.pipeline_stop || bus.pipeline_flush || !bus.id_valid) begin
         nex = empty_slot();
      end else begin
         nex.v = 1; nex.wr = bus.id_wr; nex.we = bus.id_we; nex.sel = bus.id_rf_wesl;
         nex.pc4 = bus.id_pc4; nex.ext = bus.id_ext; nex.wd = 0;
      end
      if (m_wb.v) m_cnt++;
      @(posedge clk);
      m_ex = nex; m_mem = nmem; m_wb = nwb;
      #1;
   endtask

   task automatic idle();
      bus.id_valid = 0; bus.pipeline_stop = 0; bus.pipeline_flush = 0;
   endtask

   task automatic issue(input bit [4:0] wr, input bit we, input bit [1:0] sel,
                        input bit [31:0] pc4, input bit [31:0] ext);
      bus.id_valid = 1; bus.pipeline_stop = 0; bus.pipeline_flush = 0;
      bus.id_wr = wr; bus.id_we = we; bus.id_rf_wesl = sel;
      bus.id_pc4 = pc4; bus.id_ext = ext;
   endtask

   task automatic do_reset();
      rst_n = 1;
      model_clear();
      idle();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 0;
   endtask

   task automatic test_reset();
      do_reset();
      issue(5'd1, 1, S_PC4, 32'h10, 32'h0); tick();
      issue(5'd2, 1, S_EXT, 32'h14, 32'h55); tick();
      issue(5'd3, 1, S_ALU, 32'h18, 32'h0); bus.ex_alu_c = 32'hABCD; tick();
      #2;
      rst_n = 1;
      model_clear();
      #1;
      total++;
      if ({bus.ex_wr, bus.mem_wr, bus.wb_wr, bus.ex_we, bus.mem_we, bus.wb_we, bus.ex_rf_wesl} !== '0) begin
         bad++;
         $display("FAIL reset_tuples got=%h required=0",
                  {bus.ex_wr, bus.mem_wr, bus.wb_wr, bus.ex_we, bus.mem_we, bus.wb_we, bus.ex_rf_wesl});
      end
      total++;
      if ({bus.mem_wd, bus.wb_wd, bus.wb_valid} !== '0) begin
         bad++;
         $display("FAIL reset_data got=%h required=0", {bus.mem_wd, bus.wb_wd, bus.wb_valid});
      end
`ifdef RD_TRACK_RETIRE_CNT_EN
      total++;
      if (retire_cnt !== 64'd0) begin
         bad++;
         $display("FAIL reset_retire_cnt got=%0d required=0", retire_cnt);
      end
`endif
      @(negedge clk);
      rst_n = 0;
      issue(5'd4, 1, S_EXT, 32'h0, 32'h44); tick();
      idle(); tick();
      total++;
      if (bus.wb_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_wb_early got=%b required=0", bus.wb_valid);
      end
      tick();
      total++;
      if (bus.wb_valid !== 1'b1 || bus.wb_wr !== 5'd4 || bus.wb_wd !== 32'h44) begin
         bad++;
         $display("FAIL reset_first_wb got=%b/%0d/%h required=1/4/00000044",
                  bus.wb_valid, bus.wb_wr, bus.wb_wd);
      end
   endtask

   task automatic test_alu();
      issue(5'd5, 1, S_ALU, 32'h0, 32'h0);
      bus.ex_alu_c = 32'h1234;
      tick();
      total++;
      if (bus.ex_wr !== 5'd5 || bus.ex_we !== 1'b1 || bus.ex_wd !== 32'h1234) begin
         bad++;
         $display("FAIL alu_ex got=%0d/%b/%h required=5/1/00001234", bus.ex_wr, bus.ex_we, bus.ex_wd);
      end
      idle(); tick();
      bus.ex_alu_c = 32'h7777;
      #1;
      total++;
      if (bus.mem_wd !== 32'h1234 || bus.mem_wr !== 5'd5) begin
         bad++;
         $display("FAIL alu_mem got=%h/%0d required=00001234/5", bus.mem_wd, bus.mem_wr);
      end
      tick();
      total++;
      if (bus.wb_wd !== 32'h1234 || bus.wb_we !== 1'b1) begin
         bad++;
         $display("FAIL alu_wb got=%h/%b required=00001234/1", bus.wb_wd, bus.wb_we);
      end
   endtask

   task automatic test_load();
      issue(5'd7, 1, S_DRAM, 32'h0, 32'h0);
      bus.ex_alu_c = 32'h5555;
      tick();
      total++;
      if (bus.ex_wd !== 32'h0 || bus.ex_rf_wesl !== S_DRAM) begin
         bad++;
         $display("FAIL load_ex got=%h/%0d required=00000000/1", bus.ex_wd, bus.ex_rf_wesl);
      end
      idle();
      bus.mem_dram_rd = 32'hDEADBEEF;
      tick();
      total++;
      if (bus.mem_wd !== 32'hDEADBEEF) begin
         bad++;
         $display("FAIL load_mem got=%h required=deadbeef", bus.mem_wd);
      end
      tick();
      bus.mem_dram_rd = 32'h0;
      #1;
      total++;
      if (bus.wb_wd !== 32'hDEADBEEF || bus.wb_wr !== 5'd7) begin
         bad++;
         $display("FAIL load_wb got=%h/%0d required=deadbeef/7", bus.wb_wd, bus.wb_wr);
      end
   endtask

   task automatic test_stop();
      issue(5'd3, 1, S_EXT, 32'h0, 32'h33); tick();
      issue(5'd9, 1, S_EXT, 32'h0, 32'h99);
      bus.pipeline_stop = 1;
      tick();
      total++;
      if (bus.ex_we !== 1'b0 || bus.ex_wr !== 5'd0 || bus.mem_wr !== 5'd3 || bus.mem_we !== 1'b1) begin
         bad++;
         $display("FAIL stop_bubble got=%b/%0d/%0d/%b required=0/0/3/1",
                  bus.ex_we, bus.ex_wr, bus.mem_wr, bus.mem_we);
      end
      bus.pipeline_stop = 0;
      tick();
      total++;
      if (bus.ex_wr !== 5'd9 || bus.ex_we !== 1'b1 || bus.ex_wd !== 32'h99) begin
         bad++;
         $display("FAIL stop_resume got=%0d/%b/%h required=9/1/00000099", bus.ex_wr, bus.ex_we, bus.ex_wd);
      end
      idle(); repeat (3) tick();
   endtask

   task automatic test_flush_stop();
      issue(5'd11, 1, S_PC4, 32'h40, 32'h0);
      bus.pipeline_stop = 1; bus.pipeline_flush = 1;
      tick();
      total++;
      if (bus.ex_wr !== 5'd0 || bus.ex_we !== 1'b0 || bus.ex_rf_wesl !== S_ALU) begin
         bad++;
         $display("FAIL flush_stop_ex got=%0d/%b/%0d required=0/0/0", bus.ex_wr, bus.ex_we, bus.ex_rf_wesl);
      end
      idle(); tick(); tick();
      total++;
      if (bus.wb_valid !== 1'b0) begin
         bad++;
         $display("FAIL flush_stop_wb got=%b required=0", bus.wb_valid);
      end
   endtask

   task automatic test_x0();
      issue(5'd0, 1, S_PC4, 32'h100, 32'h0); tick();
      total++;
      if (bus.ex_we !== 1'b0 || bus.ex_wd !== 32'h100) begin
         bad++;
         $display("FAIL x0_ex got=%b/%h required=0/00000100", bus.ex_we, bus.ex_wd);
      end
      idle(); tick();
      total++;
      if (bus.mem_we !== 1'b0) begin
         bad++;
         $display("FAIL x0_mem got=%b required=0", bus.mem_we);
      end
      tick();
      total++;
      if (bus.wb_we !== 1'b0 || bus.wb_valid !== 1'b1 || bus.wb_wd !== 32'h100) begin
         bad++;
         $display("FAIL x0_wb got=%b/%b/%h required=0/1/00000100", bus.wb_we, bus.wb_valid, bus.wb_wd);
      end
      tick();
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 300; i++) begin
         bus.id_valid       = ($urandom_range(0, 3) != 0);
         bus.pipeline_stop  = ($urandom_range(0, 7) == 0);
         bus.pipeline_flush = ($urandom_range(0, 7) == 0);
         bus.id_wr          = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         bus.id_we          = 1'($urandom);
         bus.id_rf_wesl     = 2'($urandom);
         bus.id_pc4         = $urandom;
         bus.id_ext         = $urandom;
         bus.ex_alu_c       = $urandom;
         bus.mem_dram_rd    = $urandom;
         tick();
         total++;
         if (bus.ex_wr !== m_ex.wr || bus.ex_we !== model_we(m_ex) || bus.ex_rf_wesl !== m_ex.sel) begin
            bad++;
            $display("FAIL rnd_ex cyc=%0d got=%0d/%b/%0d required=%0d/%b/%0d", i,
                     bus.ex_wr, bus.ex_we, bus.ex_rf_wesl, m_ex.wr, model_we(m_ex), m_ex.sel);
         end
         total++;
         if (bus.mem_wr !== m_mem.wr || bus.mem_we !== model_we(m_mem)) begin
            bad++;
            $display("FAIL rnd_mem cyc=%0d got=%0d/%b required=%0d/%b", i,
                     bus.mem_wr, bus.mem_we, m_mem.wr, model_we(m_mem));
         end
         total++;
         if (bus.wb_wr !== m_wb.wr || bus.wb_we !== model_we(m_wb) || bus.wb_valid !== m_wb.v) begin
            bad++;
            $display("FAIL rnd_wb cyc=%0d got=%0d/%b/%b required=%0d/%b/%b", i,
                     bus.wb_wr, bus.wb_we, bus.wb_valid, m_wb.wr, model_we(m_wb), m_wb.v);
         end
         if (m_ex.v) begin
            total++;
            if (bus.ex_wd !== model_ex_wd()) begin
               bad++;
               $display("FAIL rnd_ex_wd cyc=%0d got=%h required=%h", i, bus.ex_wd, model_ex_wd());
            end
         end
         if (m_mem.v) begin
            total++;
            if (bus.mem_wd !== model_mem_wd()) begin
               bad++;
               $display("FAIL rnd_mem_wd cyc=%0d got=%h required=%h", i, bus.mem_wd, model_mem_wd());
            end
         end
         if (m_wb.v) begin
            total++;
            if (bus.wb_wd !== m_wb.wd) begin
               bad++;
               $display("FAIL rnd_wb_wd cyc=%0d got=%h required=%h", i, bus.wb_wd, m_wb.wd);
            end
         end
      end
`ifdef RD_TRACK_RETIRE_CNT_EN
      total++;
      if (retire_cnt !== 64'(m_cnt)) begin
         bad++;
         $display("FAIL rnd_retire_cnt got=%0d required=%0d", retire_cnt, m_cnt);
      end
`endif
      idle(); repeat (3) tick();
   endtask

`ifdef RD_TRACK_RETIRE_CNT_EN
   task automatic test_retire_cnt();
      do_reset();
      issue(5'd1, 1, S_EXT, 32'h0, 32'h1); tick();
      issue(5'd2, 1, S_EXT, 32'h0, 32'h2); tick();
      idle(); tick();
      issue(5'd3, 1, S_EXT, 32'h0, 32'h3); tick();
      issue(5'd4, 1, S_EXT, 32'h0, 32'h4); tick();
      idle(); repeat (4) tick();
      total++;
      if (retire_cnt !== 64'd4) begin
         bad++;
         $display("FAIL retire_cnt got=%0d required=4", retire_cnt);
      end
   endtask
`endif

   initial begin
      bus.id_wr = '0; bus.id_we = 0; bus.id_rf_wesl = '0;
      bus.id_pc4 = '0; bus.id_ext = '0; bus.ex_alu_c = '0; bus.mem_dram_rd = '0;
      idle();
      model_clear();
      test_reset();
      test_alu();
      test_load();
      test_stop();
      test_flush_stop();
      test_x0();
      test_random();
`ifdef RD_TRACK_RETIRE_CNT_EN
      test_retire_cnt();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
